alu_result_checker: RTL

// Hardware response checker for the 12-bit ALU: sits beside the ALU, snoops each issued

---
 rtl/alu_result_checker.sv | 138 +++++++++++++
 1 files changed

// File: rtl/alu_result_checker.sv
// Snoops ALU commands, delays the golden result by the ALU latency and
// compares it against F; keeps run counters and the first mismatch.
module alu_result_checker #(
    parameter int             W         = 12,
    parameter int             LAT       = 1,
    parameter logic [W-1:0]   CONST_VAL = '0,
    parameter int             CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             STOP,
    input  logic             VALID,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    input  logic [2:0]       SEL,
    input  logic [W-1:0]     F,
    output logic             ERR,
    output logic [CNT_W-1:0] CHK_CNT,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [2:0]       FE_SEL,
    output logic [W-1:0]     FE_EXP,
    output logic [W-1:0]     FE_GOT,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [LAT-1:0] pv;
    logic [LAT-1:0] pv_nx;
    logic [2:0]     ps [LAT];
    logic [W-1:0]   pe [LAT];
    logic [W-1:0]   exp_v;
    logic           accept;
    logic           chk;
    logic           mism;

    // START restarts the run, so a command in the same cycle is dropped
    assign accept = VALID && (state == S_RUN) && !START;
    assign chk    = pv[LAT-1] && (state == S_RUN || state == S_DRAIN);
    assign mism   = chk && (F != pe[LAT-1]);

    always_comb begin
        exp_v = '0;
        case (SEL)
            3'b000: exp_v = A + B;
            3'b001: exp_v = A - B;
            3'b010: exp_v = A * B;
            3'b011: exp_v = A << 1;
            3'b100: exp_v = A >> 1;
            3'b101: exp_v = A + W'(1);
            3'b110: exp_v = A - W'(1);
            3'b111: exp_v = CONST_VAL;
            default: exp_v = '0;
        endcase
    end

    always_comb begin
        pv_nx[0] = accept;
        for (int i = 1; i < LAT; i++) begin
            pv_nx[i] = pv[i-1];
        end
    end

    always_comb begin
        state_nx = state;
        if (START) begin
            state_nx = S_RUN;
        end else begin
            case (state)
                S_RUN:   if (STOP) state_nx = S_DRAIN;
                S_DRAIN: if (pv_nx == '0) state_nx = S_DONE;
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || START) begin
            pv <= '0;
        end else begin
            pv <= pv_nx;
        end
        ps[0] <= SEL;
        pe[0] <= exp_v;
        for (int i = 1; i < LAT; i++) begin
            ps[i] <= ps[i-1];
            pe[i] <= pe[i-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            ERR     <= 1'b0;
            CHK_CNT <= '0;
            ERR_CNT <= '0;
            FE_SEL  <= '0;
            FE_EXP  <= '0;
            FE_GOT  <= '0;
        end else begin
            state <= state_nx;
            ERR   <= 1'b0;
            if (START) begin
                CHK_CNT <= '0;
                ERR_CNT <= '0;
                FE_SEL  <= '0;
                FE_EXP  <= '0;
                FE_GOT  <= '0;
            end else if (chk) begin
                if (CHK_CNT != '1) CHK_CNT <= CHK_CNT + CNT_W'(1);
                if (mism) begin
                    ERR <= 1'b1;
                    if (ERR_CNT != '1) ERR_CNT <= ERR_CNT + CNT_W'(1);
                    if (ERR_CNT == '0) begin
                        FE_SEL <= ps[LAT-1];
                        FE_EXP <= pe[LAT-1];
                        FE_GOT <= F;
                    end
                end
            end
        end
    end

    assign BUSY = (state == S_RUN) || (state == S_DRAIN);
    assign DONE = (state == S_DONE);
    assign PASS = DONE && (ERR_CNT == '0);

endmodule
